cmd_port_arbiter: RTL and testbench
===================================

Name: cmd_port_arbiter

Overview:
Shares the single system-controller command port (cmd_data[31:0] plus the latch_data strobe) between NUM_REQ command sources, such as the host bus bridge, a scripted sequence loader and a debug port.
- Arbitration is round-robin.
- Each granted command is driven as a well-formed latch pulse: high for HOLD_CYCLES, then low for at least GAP_CYCLES. This lets the controller's rising-edge detector capture every command exactly once.
- Sits directly upstream of system_controller.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- HOLD_CYCLES, 2, cycles latch_data is held high per command (>=1).
- GAP_CYCLES, 2, minimum cycles latch_data is low between commands (>=1).

Ports:
- clock  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester command request, level.
- req_data  input  32*NUM_REQ  command words; requester i uses bits [32*i+31:32*i].
- ack  output  NUM_REQ  one-cycle pulse: requester's command accepted.
- cmd_data  output  32  command word to system_controller.
- latch_data  output  1  command strobe to system_controller.
- grant_id  output  4  index of last granted requester.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; cmd_data=0; latch_data=0; ack=0; grant_id=0; busy=0.
  - RR pointer = NUM_REQ-1, so requester 0 wins first.
  - Assertion mid-operation aborts immediately: latch_data drops to 0 and any pending ack is lost. Requesters keep req asserted and are re-served after release.
- States (registered, encoded): IDLE, DRIVE, GAP.
- IDLE:
  - If req!=0, pick g = first set bit searching upward (with wrap) from pointer+1.
  - At the next edge: cmd_data<=req_data[g], latch_data<=1, ack[g]<=1 for one cycle, grant_id<=g, pointer<=g, cnt<=HOLD_CYCLES-1, state<=DRIVE.
  - If req==0, stay in IDLE; all outputs hold.
- DRIVE:
  - latch_data=1. If cnt==0: latch_data<=0, cnt<=GAP_CYCLES-1, state<=GAP. Else cnt decrements.
  - latch_data is high for exactly HOLD_CYCLES cycles.
- GAP:
  - latch_data=0. If cnt==0, state<=IDLE; else cnt decrements.
- Throughput:
  - Back-to-back command period = HOLD_CYCLES+GAP_CYCLES+1 cycles.
  - Latency from req (in IDLE) to latch_data rising = 1 cycle.
- cmd_data stability:
  - Stable from the latch rising edge until the next grant; it is never modified in DRIVE or GAP.
- Handshake:
  - Requester holds req and req_data stable until it sees ack.
  - It may present a new word the cycle after ack, keeping req high.
  - req is sampled only in IDLE; changes during DRIVE/GAP are ignored.
  - A requester dropping req before ack is legal; it is simply not served.
- Simultaneous requests:
  - Round-robin guarantees each active requester is served within NUM_REQ grants.
- ack and one-hot:
  - ack is one-hot or zero, never asserted outside the IDLE->DRIVE edge.
- Widths:
  - cnt width = $clog2(max(HOLD_CYCLES,GAP_CYCLES))+1.
  - grant_id zero-extended to 4 bits.

Optional Feature:
- Macro: CMD_ARB_RUN_PRIORITY_EN.
- Defined:
  - In IDLE, requests whose word has cmd[31:30]==2'b11 (run/control section) win over all others.
  - Among several such requests, round-robin applies within that subset.
  - The pointer is updated to the winner as normal.
- Undefined:
  - Pure round-robin, command contents ignored.

Decomposition:
- Shared package cmd_arb_pkg:
  - State encodings: IDLE=2'd0, DRIVE=2'd1, GAP=2'd2.
  - Command section constants: SEC_MEM=2'b00, SEC_DOT=2'b01, SEC_CFG=2'b10, SEC_RUN=2'b11.
  - Command field positions: section [31:30], select [29:26].
- One sub-module rr_pick:
  - Combinational; takes req vector and pointer, returns grant index and valid.
  - Under the macro it is instantiated twice: once on the run-section subset, once on all requests.

Test Plan:
- Reset, then req=4'b0001, req_data[0]=32'hC200_0000:
  - Next cycle: latch_data=1, ack=4'b0001, cmd_data=32'hC200_0000.
  - latch_data high 2 cycles, low 2; busy low 5 cycles after the grant edge.
- req=4'b1111 held continuously with distinct words:
  - Grants in order 0,1,2,3,0; rising edges of latch_data spaced exactly 5 cycles.
- Requester 2 drops req during DRIVE of requester 1:
  - Next grant skips 2, goes to 3; no ack[2] issued.
- Assert reset_n=0 mid-DRIVE:
  - latch_data=0, busy=0 asynchronously.
  - After release with req=4'b0010: grant to 1 in 1 cycle.
- CMD_ARB_RUN_PRIORITY_EN defined, req=4'b0011, word0=32'h0000_1234, word1=32'hC000_0000:
  - Requester 1 granted first, then 0.
  - Without the macro: 0 first.
- HOLD_CYCLES=1, GAP_CYCLES=1 build, req=4'b0001 held:
  - latch_data toggles 1,0,0 pattern, period 3 cycles.
  - Each pulse accompanied by exactly one ack.

Source files
------------

// File: rtl/cmd_arb_pkg.sv
// Shared definitions for the command-port arbiter: FSM state encoding,
// command section codes and command field positions.
package cmd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [1:0] SEC_MEM = 2'b00;
    localparam logic [1:0] SEC_DOT = 2'b01;
    localparam logic [1:0] SEC_CFG = 2'b10;
    localparam logic [1:0] SEC_RUN = 2'b11;

    localparam int SEC_MSB = 31;
    localparam int SEC_LSB = 30;
    localparam int SEL_MSB = 29;
    localparam int SEL_LSB = 26;

    // True when a command word targets the run/control section.
    function automatic logic is_run_cmd(input logic [31:0] word);
        return word[SEC_MSB:SEC_LSB] == SEC_RUN;
    endfunction

endpackage

// File: rtl/cmd_port_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request found
// searching upward (with wrap) from the position just after ptr.
module rr_pick
    import cmd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      grant,
    output logic               valid
);

    // Scan all NUM_REQ positions starting after ptr; first hit wins.
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!valid && req[idx[IW-1:0]]) begin
                valid = 1'b1;
                grant = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cmd_port_arbiter.sv
// Round-robin arbiter sharing the system-controller command port between
// NUM_REQ sources. Each grant produces a latch_data pulse HOLD_CYCLES high
// followed by at least GAP_CYCLES low so the downstream rising-edge detector
// sees every command exactly once.
// Optional build macro CMD_ARB_RUN_PRIORITY_EN: run-section commands
// (word[31:30] == 2'b11) win over all other pending requests.
module cmd_port_arbiter
    import cmd_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]    ack,
    output logic [31:0]           cmd_data,
    output logic                  latch_data,
    output logic [3:0]            grant_id,
    output logic                  busy
);

    localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [31:0]          cmd_q, cmd_d;
    logic                 latch_q, latch_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [3:0]           gid_q, gid_d;

    logic [31:0]          word [NUM_REQ];
    logic [IW-1:0]        pick_g;
    logic                 pick_v;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign word[gi] = req_data[32*gi +: 32];
        end
    endgenerate

`ifdef CMD_ARB_RUN_PRIORITY_EN
    logic [NUM_REQ-1:0] run_req;
    logic [IW-1:0]      run_g, all_g;
    logic               run_v, all_v;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_run
            assign run_req[gi] = req[gi] && is_run_cmd(word[gi]);
        end
    endgenerate

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick_run (
        .req   (run_req),
        .ptr   (ptr_q),
        .grant (run_g),
        .valid (run_v)
    );

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick_all (
        .req   (req),
        .ptr   (ptr_q),
        .grant (all_g),
        .valid (all_v)
    );

    // A pending run-section command preempts the plain round-robin choice.
    assign pick_g = run_v ? run_g : all_g;
    assign pick_v = all_v;
`else
    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick_all (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_g),
        .valid (pick_v)
    );
`endif

    // Next-state and output computation for the IDLE/DRIVE/GAP sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cmd_d   = cmd_q;
        latch_d = latch_q;
        ack_d   = '0;
        gid_d   = gid_q;
        case (state_q)
            IDLE: begin
                if (pick_v) begin
                    cmd_d         = word[pick_g];
                    latch_d       = 1'b1;
                    ack_d[pick_g] = 1'b1;
                    gid_d         = 4'(pick_g);
                    ptr_d         = pick_g;
                    cnt_d         = CW'(HOLD_CYCLES - 1);
                    state_d       = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    latch_d = 1'b0;
                    cnt_d   = CW'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                latch_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= IW'(NUM_REQ - 1);
            cmd_q   <= '0;
            latch_q <= 1'b0;
            ack_q   <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_d;
            latch_q <= latch_d;
            ack_q   <= ack_d;
            gid_q   <= gid_d;
        end
    end

    assign ack        = ack_q;
    assign cmd_data   = cmd_q;
    assign latch_data = latch_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cmd_port_arbiter.sv
// Self-checking bench for cmd_port_arbiter: a timeline model of the grant
// schedule is compared against the DUT every cycle, plus literal checks.
module tb_cmd_port_arbiter;

    localparam int N = 4;
    localparam int H = 2;
    localparam int G = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req;
    logic [32*N-1:0]   req_data;
    logic [N-1:0]      ack;
    logic [31:0]       cmd_data;
    logic              latch_data;
    logic [3:0]        grant_id;
    logic              busy;

    logic [N-1:0]      req_f;
    logic [32*N-1:0]   req_data_f;
    logic [N-1:0]      ack_f;
    logic [31:0]       cmd_f;
    logic              latch_f;
    logic [3:0]        gid_f;
    logic              busy_f;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    bit auto_upd = 1'b0;
    bit drop_on_ack = 1'b0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    cmd_port_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data),
        .ack(ack), .cmd_data(cmd_data), .latch_data(latch_data),
        .grant_id(grant_id), .busy(busy)
    );

    cmd_port_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_fast (
        .clock(clock), .reset_n(reset_n), .req(req_f), .req_data(req_data_f),
        .ack(ack_f), .cmd_data(cmd_f), .latch_data(latch_f),
        .grant_id(gid_f), .busy(busy_f)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Winner: first requester after 'last' (wrapping); run-section words first
    // when the priority build is selected.
    function automatic int model_pick(input logic [N-1:0] r, input logic [32*N-1:0] d,
                                      input int last);
        logic [N-1:0] cand;
        cand = r;
`ifdef CMD_ARB_RUN_PRIORITY_EN
        begin
            logic [N-1:0] run;
            run = '0;
            for (int i = 0; i < N; i++)
                if (r[i] && d[32*i+30 +: 2] == 2'b11) run[i] = 1'b1;
            if (run != 0) cand = run;
        end
`endif
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (cand[idx]) return idx;
        end
        return -1;
    endfunction

    // Model: m_t counts cycles since the grant edge (0 = ready to grant).
    // Latch is high for t in 1..H, busy for t in 1..H+G.
    int          m_t;
    int          m_last;
    logic [31:0] m_cmd;
    logic [N-1:0] m_ack;
    logic [3:0]  m_gid;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_t = 0; m_last = N - 1; m_cmd = '0; m_ack = '0; m_gid = '0;
        end else if (m_t == 0) begin
            int g;
            g = model_pick(req, req_data, m_last);
            m_ack = '0;
            if (g >= 0) begin
                m_cmd = req_data[32*g +: 32];
                m_ack[g] = 1'b1;
                m_gid = 4'(g);
                m_last = g;
                m_t = 1;
            end
        end else begin
            m_ack = '0;
            m_t = (m_t == H + G) ? 0 : m_t + 1;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("latch", 32'(latch_data), 32'(m_t >= 1 && m_t <= H));
            chk("busy", 32'(busy), 32'(m_t != 0));
            chk("ack", 32'(ack), 32'(m_ack));
            chk("cmd_data", cmd_data, m_cmd);
            chk("grant_id", 32'(grant_id), 32'(m_gid));
        end
    end

    // Transaction monitor: grant order and latch rising-edge cycles.
    int   gq[$];
    int   rq[$];
    logic prev_latch = 1'b0;
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (ack[i] === 1'b1) begin
                gq.push_back(i);
                $display("grant cycle=%0d id=%0d data=%h", cyc, i, cmd_data);
            end
        end
        if (latch_data === 1'b1 && prev_latch !== 1'b1) rq.push_back(cyc);
        prev_latch = latch_data;
    end

    task automatic tick();
        @(negedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack[i] === 1'b1) begin
                if (auto_upd) req_data[32*i +: 32] = req_data[32*i +: 32] + 32'h10;
                if (drop_on_ack) req[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        req = '0;
        reset_n = 1'b0;
        tick();
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        gq.delete();
        rq.delete();
    endtask

    task automatic wait_grants(input int n, input int budget, input string nm);
        int k;
        k = 0;
        while (gq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(nm, 32'(gq.size() >= n), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_l[4];
        int exp_b[4];
        int exp_g[5];
        req = '0; req_data = '0; req_f = '0; req_data_f = '0;
        reset_n = 1'b0;
        tick();
        cmp_en = 1'b1;
        do_reset();

        // Reset values
        chk("rst_latch", 32'(latch_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_cmd", cmd_data, 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);

        // Single request from requester 0
        req_data[31:0] = 32'hC200_0000;
        req = 4'b0001;
        tick();
        chk("t1_latch", 32'(latch_data), 32'd1);
        chk("t1_ack", 32'(ack), 32'h1);
        chk("t1_cmd", cmd_data, 32'hC200_0000);
        req = '0;
        exp_l = '{1, 0, 0, 0};
        exp_b = '{1, 1, 1, 0};
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("t1_pulse_latch", 32'(latch_data), 32'(exp_l[j]));
            chk("t1_pulse_busy", 32'(busy), 32'(exp_b[j]));
        end

        // All four requesting continuously, new word after each ack
        do_reset();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'h1000_0000 * (i + 1);
        req = 4'b1111;
        auto_upd = 1'b1;
        wait_grants(5, 40, "t2_timeout");
        req = '0;
        auto_upd = 1'b0;
        exp_g = '{0, 1, 2, 3, 0};
        for (int j = 0; j < 5 && j < gq.size(); j++) chk("t2_order", 32'(gq[j]), 32'(exp_g[j]));
        for (int j = 1; j < 5 && j < rq.size(); j++) chk("t2_spacing", 32'(rq[j] - rq[j-1]), 32'd5);
        drain();

        // Requester 2 withdraws during requester 1's DRIVE
        gq.delete();
        req = 4'b1110;
        wait_grants(1, 20, "t3_timeout_a");
        chk("t3_first", 32'(gq[0]), 32'd1);
        req = 4'b1000;
        wait_grants(2, 20, "t3_timeout_b");
        req = '0;
        if (gq.size() >= 2) chk("t3_second", 32'(gq[1]), 32'd3);
        drain();
        chk("t3_count", 32'(gq.size()), 32'd2);

        // Reset in the middle of DRIVE
        gq.delete();
        req = 4'b0001;
        wait_grants(1, 20, "t4_timeout");
        reset_n = 1'b0;
        #1;
        chk("t4_async_latch", 32'(latch_data), 32'd0);
        chk("t4_async_busy", 32'(busy), 32'd0);
        chk("t4_async_ack", 32'(ack), 32'd0);
        req = 4'b0010;
        tick();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        chk("t4_regrant_latch", 32'(latch_data), 32'd1);
        chk("t4_regrant_ack", 32'(ack), 32'h2);
        chk("t4_regrant_gid", 32'(grant_id), 32'd1);
        req = '0;
        drain();

        // Run-section priority
        do_reset();
        req_data[31:0]  = 32'h0000_1234;
        req_data[63:32] = 32'hC000_0000;
        drop_on_ack = 1'b1;
        req = 4'b0011;
        wait_grants(2, 30, "t5_timeout");
        drop_on_ack = 1'b0;
        req = '0;
`ifdef CMD_ARB_RUN_PRIORITY_EN
        chk("t5_first", 32'(gq[0]), 32'd1);
        if (gq.size() >= 2) chk("t5_second", 32'(gq[1]), 32'd0);
`else
        chk("t5_first", 32'(gq[0]), 32'd0);
        if (gq.size() >= 2) chk("t5_second", 32'(gq[1]), 32'd1);
`endif
        drain();

        // HOLD=1/GAP=1 instance: period 3, one ack per pulse
        req_data_f[31:0] = 32'h5A5A_0001;
        req_f = 4'b0001;
        for (int j = 0; j < 9; j++) begin
            tick();
            chk("t6_latch", 32'(latch_f), 32'(j % 3 == 0));
            chk("t6_ack", 32'(ack_f), 32'(j % 3 == 0));
            chk("t6_cmd", cmd_f, 32'h5A5A_0001);
        end
        req_f = '0;
        tick();
        tick();

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
